// File: rtl/regfile_arbiter.sv
// Two-requester register-file arbiter: round-robin grants with optional locked
// atomic sequences (bounded by LOCK_MAX beats) and a registered response stage.
module regfile_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        lock,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              locked
);

    typedef enum logic {
        ST_RR     = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              owner_q, owner_d;
    logic [7:0]        lock_cnt_q, lock_cnt_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              grant_any;
    logic              grant_idx;
    logic              grant_live;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RR;
            last_gnt_q  <= 1'b1;
            owner_q     <= 1'b0;
            lock_cnt_q  <= 8'd0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            owner_q     <= owner_d;
            lock_cnt_q  <= lock_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        grant_any  = 1'b0;
        grant_idx  = 1'b0;
        case (state_q)
            ST_RR: begin
                if (req != 2'b00) begin
                    grant_any  = 1'b1;
                    grant_idx  = (req == 2'b11) ? ~last_gnt_q : req[1];
                    last_gnt_d = grant_idx;
                    if (lock[grant_idx]) begin
                        state_d    = ST_LOCKED;
                        owner_d    = grant_idx;
                        lock_cnt_d = 8'd1;
                    end
                end
            end
            ST_LOCKED: begin
                // Exhausted budget or owner gone: idle one cycle and hand the next contest to the other side
                if ((lock_cnt_q >= LOCK_LIMIT) || !req[owner_q]) begin
                    state_d    = ST_RR;
                    last_gnt_d = owner_q;
                    lock_cnt_d = 8'd0;
                end else begin
                    grant_any = 1'b1;
                    grant_idx = owner_q;
                    if (lock[owner_q]) begin
                        lock_cnt_d = lock_cnt_q + 8'd1;
                    end else begin
                        state_d    = ST_RR;
                        last_gnt_d = owner_q;
                        lock_cnt_d = 8'd0;
                    end
                end
            end
            default: begin
                state_d = ST_RR;
            end
        endcase
    end

    always_comb begin
        // Reset must silence the combinational grant path as well as the flops
        grant_live  = grant_any && rst;
        sel_we      = grant_idx ? we[1] : we[0];
        sel_addr    = grant_idx ? addr1 : addr0;
        sel_wdata   = grant_idx ? wdata1 : wdata0;
        gnt         = 2'b00;
        rf_we       = 1'b0;
        rf_addr     = '0;
        rf_wdata    = '0;
        rsp_rdata_d = '0;
        if (grant_live) begin
            gnt         = grant_idx ? 2'b10 : 2'b01;
            rf_we       = sel_we && (sel_addr != '0);
            rf_addr     = sel_addr;
            rf_wdata    = sel_wdata;
            rsp_rdata_d = sel_we ? '0 : rf_rdata;
        end
        rsp_valid_d = gnt;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign locked    = (state_q == ST_LOCKED);

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, register data width.
REQ-002 Parameter: ADDR_W, default 5, register index width.
REQ-003 Parameter: LOCK_MAX, default 16, maximum consecutive locked grant cycles before forced release (range 1..255).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 req  input  2  per-requester access request; held until granted.
REQ-008 lock  input  2  per-requester atomic-sequence hold, sampled with req.
REQ-009 we  input  2  per-requester write enable; 0 means read.
REQ-010 addr0, addr1  input  ADDR_W  requester 0 and 1 register index.
REQ-011 wdata0, wdata1  input  DATA_W  requester 0 and 1 write data.
REQ-012 gnt  output  2  one-hot-or-zero grant, combinational, same cycle as access.
REQ-013 rsp_valid  output  2  registered one-cycle completion pulse per requester.
REQ-014 rsp_rdata  output  DATA_W  registered read data accompanying rsp_valid.
REQ-015 rf_we, rf_addr, rf_wdata  output  1/ADDR_W/DATA_W  register-file write port drive.
REQ-016 rf_rdata  input  DATA_W  combinational register-file read data at rf_addr.
REQ-017 locked  output  1  high while FSM is in LOCKED.

Function
REQ-018 FSM states: RR (round-robin), LOCKED; registers: last_gnt (1 bit), owner (1 bit), lock_cnt (8 bits).
REQ-019 At most one gnt bit SHALL be high per cycle; the granted requester's we/addr/wdata SHALL drive rf_* combinationally that cycle.
REQ-020 No grant: rf_we=0, rf_addr=0, rf_wdata=0.
REQ-021 RR, single req: grant it; both req: grant requester != last_gnt; last_gnt <= granted index.
REQ-022 RR, granted with lock=1: next state LOCKED, owner <= granted, lock_cnt <= 1.
REQ-023 LOCKED: only owner eligible; non-owner req SHALL receive no gnt.
REQ-024 LOCKED, owner req=1 lock=1, lock_cnt < LOCK_MAX: grant, stay, lock_cnt++.
REQ-025 LOCKED, owner req=1 lock=0: grant (final beat), next state RR, last_gnt <= owner.
REQ-026 LOCKED, owner req=0: no grant this cycle, next state RR, last_gnt <= owner.
REQ-027 LOCKED, lock_cnt == LOCK_MAX: no grant this cycle, forced return to RR, last_gnt <= owner (other requester wins next contest).
REQ-028 Write to index 0: gnt and rsp_valid issued normally, rf_we SHALL be held 0.
REQ-029 rsp_valid[i] SHALL pulse exactly the cycle after gnt[i]; rsp_rdata = rf_rdata captured at grant for reads, 0 for writes.
REQ-030 Fairness: in RR with both requests continuously asserted and lock=0, grants SHALL alternate every cycle.
REQ-031 Latency: access to register file 0 cycles after grant; response 1 cycle.

Reset
REQ-032 rst low SHALL immediately force: state RR, last_gnt=1, owner=0, lock_cnt=0, rsp_valid=0, rsp_rdata=0, gnt=0, rf_we=0, locked=0.
REQ-033 Reset asserted mid-LOCKED SHALL abandon the sequence; no rsp_valid pulse for the in-flight cycle.
REQ-034 First contest after reset SHALL be won by requester 0.

Verification
REQ-035 Both req, lock=0, reads of 2 and 3 (r2=5, r3=7) -> gnt 01,10,01,...; rsp_rdata 5 then 7 each one cycle later.
REQ-036 Req1 write addr 0 data 0xFFFF -> gnt[1]=1, rf_we=0, rsp_valid[1] next cycle, r0 unchanged.
REQ-037 Req0 lock=1 for 3 beats then lock=0, req1 held high -> 4 consecutive gnt[0], then gnt[1]; locked high 3 cycles.
REQ-038 LOCK_MAX=4, req0 lock held 1 continuously, req1 high -> 4 gnt[0], one idle cycle, then gnt[1].
REQ-039 Assert rst during LOCKED -> locked, gnt, rsp_valid drop asynchronously; after release, both req -> gnt[0] first.
REQ-040 Req0 write r4=9 then read r4 next cycle -> rsp_rdata=9.
